// File: rtl/pipelined_ripple_adder.sv
// Pipelined ripple-carry add/subtract: each stage ripples one SLICE of the operands.
// Unconsumed operand bits ride forward in skew registers; finished sum bits ride in deskew registers.
module pipelined_ripple_adder #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] input_a,
   input  logic [WIDTH-1:0] input_b,
   input  logic             carry_in,
   input  logic             sub_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] final_sum,
   output logic             carry_out,
   output logic             overflow
);

   localparam int SLICE = WIDTH / STAGES;

   logic             w_adv;
   logic [WIDTH-1:0] w_b_eff;
   logic             w_c0;

   // The whole pipeline moves as one; a full output register that is not taken freezes every stage.
   assign w_adv    = ~out_valid | out_ready;
   assign in_ready = w_adv;

   // Subtraction is A + ~B + 1, so carry_in is overridden and the inverted B travels with the op.
   assign w_b_eff = sub_mode ? ~input_b : input_b;
   assign w_c0    = sub_mode | carry_in;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam int REM = WIDTH - k * SLICE;

      logic [REM-1:0]         w_a_rem;
      logic [REM-1:0]         w_b_rem;
      logic                   w_v_in;
      logic                   w_c_in;
      logic [SLICE:0]         w_slice;
      logic [(k+1)*SLICE-1:0] w_s_nxt;

      logic                   r_v;
      logic                   r_c;
      logic [(k+1)*SLICE-1:0] r_s;

      if (k == 0) begin : g_src
         assign w_a_rem = input_a;
         assign w_b_rem = w_b_eff;
         assign w_c_in  = w_c0;
         assign w_v_in  = in_valid;
      end else begin : g_src
         assign w_a_rem = g_stage[k-1].g_skew.r_a;
         assign w_b_rem = g_stage[k-1].g_skew.r_b;
         assign w_c_in  = g_stage[k-1].r_c;
         assign w_v_in  = g_stage[k-1].r_v;
      end

      assign w_slice = {1'b0, w_a_rem[SLICE-1:0]} + {1'b0, w_b_rem[SLICE-1:0]}
                     + {{SLICE{1'b0}}, w_c_in};

      if (k == 0) begin : g_dsk
         assign w_s_nxt = w_slice[SLICE-1:0];
      end else begin : g_dsk
         assign w_s_nxt = {w_slice[SLICE-1:0], g_stage[k-1].r_s};
      end

      // NOTE: datapath registers are reset along with the valid bits so the outputs read zero after reset.
      always_ff @(posedge clk) begin
         if (reset) begin
            r_v <= 1'b0;
            r_c <= 1'b0;
            r_s <= '0;
         end else if (w_adv) begin
            r_v <= w_v_in;
            r_c <= w_slice[SLICE];
            r_s <= w_s_nxt;
         end
      end

      if (k < STAGES - 1) begin : g_skew
         logic [REM-SLICE-1:0] r_a;
         logic [REM-SLICE-1:0] r_b;

         always_ff @(posedge clk) begin
            if (reset) begin
               r_a <= '0;
               r_b <= '0;
            end else if (w_adv) begin
               r_a <= w_a_rem[REM-1:SLICE];
               r_b <= w_b_rem[REM-1:SLICE];
            end
         end
      end else begin : g_last
         logic w_c_msb;
         logic r_ovf;

         // Carry into the MSB recovered from the sum bit: s = a ^ b ^ c.
         assign w_c_msb = w_a_rem[SLICE-1] ^ w_b_rem[SLICE-1] ^ w_slice[SLICE-1];

         always_ff @(posedge clk) begin
            if (reset) begin
               r_ovf <= 1'b0;
            end else if (w_adv) begin
               r_ovf <= w_c_msb ^ w_slice[SLICE];
            end
         end
      end
   end

   assign out_valid = g_stage[STAGES-1].r_v;
   assign final_sum = g_stage[STAGES-1].r_s;
   assign carry_out = g_stage[STAGES-1].r_c;
   assign overflow  = g_stage[STAGES-1].g_last.r_ovf;

endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// Scoreboard bench: three adder configurations share one stimulus stream,
// each with its own expected-result queue checked when its output transfers.
module tb_pipelined_ripple_adder;

   typedef struct packed {
      logic [65:0] exp;
      int          t;
      int          st;
   } exp_t;

   localparam int W [3] = '{32, 8, 64};
   localparam int S [3] = '{4, 2, 8};

   logic        clk = 1'b0;
   logic        rst;
   logic        drv_valid, drv_cin, drv_sub, drv_ordy;
   logic [63:0] drv_a, drv_b;

   logic        rdy [3];
   logic        vld [3];
   logic        co  [3];
   logic        ovf [3];
   logic [63:0] sum [3];
   logic [31:0] s32;
   logic [7:0]  s8;
   logic [63:0] s64;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   int   stall_cnt = 0;
   logic prev_rst = 1'b0;
   logic        hold [3];
   logic [65:0] held [3];
   exp_t        sb [3][$];

   always #5 clk = ~clk;

   pipelined_ripple_adder #(.WIDTH(32), .STAGES(4)) u_add32 (
      .clk(clk), .reset(rst), .in_valid(drv_valid), .in_ready(rdy[0]),
      .input_a(drv_a[31:0]), .input_b(drv_b[31:0]), .carry_in(drv_cin), .sub_mode(drv_sub),
      .out_valid(vld[0]), .out_ready(drv_ordy), .final_sum(s32), .carry_out(co[0]), .overflow(ovf[0]));

   pipelined_ripple_adder #(.WIDTH(8), .STAGES(2)) u_add8 (
      .clk(clk), .reset(rst), .in_valid(drv_valid), .in_ready(rdy[1]),
      .input_a(drv_a[7:0]), .input_b(drv_b[7:0]), .carry_in(drv_cin), .sub_mode(drv_sub),
      .out_valid(vld[1]), .out_ready(drv_ordy), .final_sum(s8), .carry_out(co[1]), .overflow(ovf[1]));

   pipelined_ripple_adder #(.WIDTH(64), .STAGES(8)) u_add64 (
      .clk(clk), .reset(rst), .in_valid(drv_valid), .in_ready(rdy[2]),
      .input_a(drv_a), .input_b(drv_b), .carry_in(drv_cin), .sub_mode(drv_sub),
      .out_valid(vld[2]), .out_ready(drv_ordy), .final_sum(s64), .carry_out(co[2]), .overflow(ovf[2]));

   assign sum[0] = {32'd0, s32};
   assign sum[1] = {56'd0, s8};
   assign sum[2] = s64;

   task automatic check(input string tag, input logic [65:0] got, input logic [65:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Golden model: {overflow, carry_out, sum} for a w-bit add/sub.
   function automatic logic [65:0] model(input logic [63:0] a, input logic [63:0] b,
                                         input logic cin, input logic sub, input int w);
      logic [63:0] mask, am, bm, s;
      logic [64:0] full;
      logic        c, v;
      mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
      am   = a & mask;
      bm   = (sub ? ~b : b) & mask;
      full = {1'b0, am} + {1'b0, bm} + {64'd0, (sub | cin)};
      s    = full[63:0] & mask;
      c    = full[w];
      v    = (am[w-1] == bm[w-1]) && (s[w-1] != am[w-1]);
      return {v, c, s};
   endfunction

   always @(negedge clk) begin
      exp_t e;
      cyc++;
      if (!drv_ordy) stall_cnt++;
      for (int i = 0; i < 3; i++) begin
         if (prev_rst) begin
            check($sformatf("rst_out_valid[%0d]", i), vld[i], 66'd0);
            check($sformatf("rst_outputs[%0d]", i), {ovf[i], co[i], sum[i]}, 66'd0);
            check($sformatf("rst_in_ready[%0d]", i), rdy[i], 66'd1);
         end
         if (rst) begin
            sb[i].delete();
            hold[i] = 1'b0;
         end else begin
            if (hold[i])
               check($sformatf("hold_stable[%0d]", i), {ovf[i], co[i], sum[i]}, held[i]);
            if (vld[i] && !drv_ordy)
               check($sformatf("stall_in_ready[%0d]", i), rdy[i], 66'd0);
            if (vld[i] && drv_ordy) begin
               check($sformatf("expected_pending[%0d]", i), (sb[i].size() != 0), 66'd1);
               if (sb[i].size() != 0) begin
                  e = sb[i].pop_front();
                  check($sformatf("result[%0d]", i), {ovf[i], co[i], sum[i]}, e.exp);
                  if (e.st == stall_cnt)
                     check($sformatf("latency[%0d]", i), 66'(cyc - e.t), 66'(S[i]));
               end
            end
            if (drv_valid && rdy[i]) begin
               e.exp = model(drv_a, drv_b, drv_cin, drv_sub, W[i]);
               e.t   = cyc;
               e.st  = stall_cnt;
               sb[i].push_back(e);
            end
            hold[i] = vld[i] && !drv_ordy;
            held[i] = {ovf[i], co[i], sum[i]};
         end
      end
      prev_rst = rst;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input logic [63:0] a, input logic [63:0] b, input logic cin, input logic sub);
      drv_a   = a;
      drv_b   = b;
      drv_cin = cin;
      drv_sub = sub;
   endtask

   // Offer an op until the 32-bit unit takes it (bounded).
   task automatic send(input logic [63:0] a, input logic [63:0] b, input logic cin, input logic sub);
      logic ok;
      ok = 1'b0;
      set_op(a, b, cin, sub);
      drv_valid = 1'b1;
      for (int n = 0; n < 50; n++) begin
         #1;
         ok = rdy[0];
         step();
         if (ok) break;
      end
      if (!ok) check("send_accept_timeout", 66'(ok), 66'd1);
      drv_valid = 1'b0;
   endtask

   initial begin
      int pending;
      rst = 1'b1;
      drv_valid = 1'b0;
      drv_ordy  = 1'b1;
      set_op(64'd0, 64'd0, 1'b0, 1'b0);
      step();
      step();
      rst = 1'b0;
      step();

      // Directed vectors, including carry through every slice and signed overflow.
      send(64'h0000_0005, 64'h0000_0003, 1'b0, 1'b0);
      send(64'hFFFF_FFFF, 64'h0000_0001, 1'b0, 1'b0);
      send(64'h7FFF_FFFF, 64'h0000_0001, 1'b0, 1'b0);
      send(64'h8000_0000, 64'h0000_0001, 1'b0, 1'b1);
      send(64'h0000_00FF, 64'h0000_0001, 1'b1, 1'b0);
      send(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
      repeat (10) step();

      // 16 back-to-back random ops with a 3-cycle downstream stall mid-stream.
      for (int j = 0; j < 16; j++) begin
         if (j == 8) begin
            set_op({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'($urandom));
            drv_valid = 1'b1;
            drv_ordy  = 1'b0;
            repeat (3) step();
            drv_ordy  = 1'b1;
         end
         send({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'($urandom));
      end
      repeat (12) step();

      // Reset with ops in flight; the op offered in the reset cycle must be dropped.
      for (int j = 0; j < 3; j++)
         send({$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 1'($urandom));
      set_op({$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 1'b0);
      drv_valid = 1'b1;
      rst = 1'b1;
      step();
      rst = 1'b0;
      drv_valid = 1'b0;
      repeat (12) step();

      // Random mixed add/sub with random bubbles and back-pressure.
      for (int j = 0; j < 120; j++) begin
         drv_ordy  = ($urandom_range(0, 3) != 0);
         drv_valid = ($urandom_range(0, 4) != 0);
         set_op({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'($urandom));
         step();
      end

      drv_valid = 1'b0;
      drv_ordy  = 1'b1;
      for (int n = 0; n < 200; n++) begin
         if (sb[0].size() + sb[1].size() + sb[2].size() == 0) break;
         step();
      end
      pending = sb[0].size() + sb[1].size() + sb[2].size();
      check("drained_all", 66'(pending), 66'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
